// File: rtl/combo_lock_pkg.sv
// ============================================================================
// Module   : combo_lock_pkg
// Purpose  : Shared state enumeration, default sizes and width helper for the
//            combination lock. COMBO_LOCK_PROGRAM_EN adds the PROGRAM state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package combo_lock_pkg;

  localparam int DEFAULT_CODE_LEN = 4;
  localparam int DEFAULT_DIGIT_W  = 4;

  typedef enum logic [2:0] {
    ST_ENTRY    = 3'd0,
    ST_CHECK    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_FAIL     = 3'd3,
    ST_LOCKOUT  = 3'd4
`ifdef COMBO_LOCK_PROGRAM_EN
    , ST_PROGRAM = 3'd5
`endif
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lockout_timer.sv
// ============================================================================
// Module   : lockout_timer
// Purpose  : One-shot timer; done is high in the CYCLES-th cycle after start.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lockout_timer
  import combo_lock_pkg::*;
#(
  parameter int CYCLES = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);

  localparam int               CNT_W  = clog2w(CYCLES + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // The counter stops at C_LAST and returns to idle, so it can never wrap.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(1);
    end else if (busy_q) begin
      if (cnt_q == C_LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done = busy_q && (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/combo_lock_checker.sv
// ============================================================================
// Module   : combo_lock_checker
// Purpose  : Digit-by-digit combination lock with retry limit and lockout.
//            Define COMBO_LOCK_PROGRAM_EN to allow reprogramming while open.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module combo_lock_checker
  import combo_lock_pkg::*;
#(
  parameter int                          CODE_LEN       = DEFAULT_CODE_LEN,
  parameter int                          DIGIT_W        = DEFAULT_DIGIT_W,
  parameter logic [CODE_LEN*DIGIT_W-1:0] CODE           = 16'h1234,
  parameter int                          MAX_TRIES      = 3,
  parameter int                          LOCKOUT_CYCLES = 100000000
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [DIGIT_W-1:0]                   digit,
  input  logic                                 enter,
  input  logic                                 clear,
  output logic                                 unlocked,
  output logic                                 alarm,
  output logic [clog2w(CODE_LEN+1)-1:0]        entry_pos,
  output logic [CODE_LEN*DIGIT_W-1:0]          entered,
  output logic [clog2w(MAX_TRIES+1)-1:0]       fail_cnt
);

  localparam int                CODE_W     = CODE_LEN * DIGIT_W;
  localparam int                POS_W      = clog2w(CODE_LEN + 1);
  localparam int                FAIL_W     = clog2w(MAX_TRIES + 1);
  localparam logic [POS_W-1:0]  C_LAST_POS = POS_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] C_MAX_FAIL = FAIL_W'(MAX_TRIES);

  state_t              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [CODE_W-1:0]   entered_q, entered_d;
  logic                mismatch_q, mismatch_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [FAIL_W-1:0]   fail_inc;
  logic [CODE_W-1:0]   code_cur;
  logic [DIGIT_W-1:0]  code_nib;
  logic                timer_start;
  logic                timer_done;

`ifdef COMBO_LOCK_PROGRAM_EN
  logic [CODE_W-1:0] code_q, code_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) code_q <= CODE;
    else        code_q <= code_d;
  end

  assign code_cur = code_q;
`else
  assign code_cur = CODE;
`endif

  assign fail_inc = fail_q + FAIL_W'(1);

  // Stored-code digit at the current entry position (first digit is MS).
  always_comb begin
    code_nib = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (pos_q == POS_W'(i)) code_nib = code_cur[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    entered_d   = entered_q;
    mismatch_d  = mismatch_q;
    fail_d      = fail_q;
    timer_start = 1'b0;
`ifdef COMBO_LOCK_PROGRAM_EN
    code_d      = code_q;
`endif
    case (state_q)
      ST_ENTRY: begin
        if (clear) begin
          pos_d      = '0;
          entered_d  = '0;
          mismatch_d = 1'b0;
        end else if (enter) begin
          for (int i = 0; i < CODE_LEN; i++) begin
            if (pos_q == POS_W'(i)) entered_d[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit;
          end
          pos_d = pos_q + POS_W'(1);
          if (digit != code_nib) mismatch_d = 1'b1;
          if (pos_q == C_LAST_POS) state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (mismatch_q) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_UNLOCKED;
          fail_d  = '0;
        end
      end

      ST_FAIL: begin
        fail_d     = fail_inc;
        pos_d      = '0;
        entered_d  = '0;
        mismatch_d = 1'b0;
        if (fail_inc == C_MAX_FAIL) begin
          state_d     = ST_LOCKOUT;
          timer_start = 1'b1;
        end else begin
          state_d = ST_ENTRY;
        end
      end

      ST_UNLOCKED: begin
`ifdef COMBO_LOCK_PROGRAM_EN
        if (clear) begin
          state_d    = ST_PROGRAM;
          pos_d      = '0;
          entered_d  = '0;
          mismatch_d = 1'b0;
        end
`else
        if (enter || clear) begin
          state_d    = ST_ENTRY;
          pos_d      = '0;
          entered_d  = '0;
          mismatch_d = 1'b0;
        end
`endif
      end

      ST_LOCKOUT: begin
        if (timer_done) begin
          state_d    = ST_ENTRY;
          fail_d     = '0;
          pos_d      = '0;
          entered_d  = '0;
          mismatch_d = 1'b0;
        end
      end

`ifdef COMBO_LOCK_PROGRAM_EN
      // entry_pos doubles as the write index while programming.
      ST_PROGRAM: begin
        if (enter) begin
          for (int i = 0; i < CODE_LEN; i++) begin
            if (pos_q == POS_W'(i)) code_d[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit;
          end
          pos_d = pos_q + POS_W'(1);
          if (pos_q == C_LAST_POS) begin
            state_d = ST_ENTRY;
            pos_d   = '0;
          end
        end
      end
`endif

      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ENTRY;
      pos_q      <= '0;
      entered_q  <= '0;
      mismatch_q <= 1'b0;
      fail_q     <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      entered_q  <= entered_d;
      mismatch_q <= mismatch_d;
      fail_q     <= fail_d;
    end
  end

  lockout_timer #(
    .CYCLES (LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (timer_start),
    .done  (timer_done)
  );

  assign unlocked  = (state_q == ST_UNLOCKED);
  assign alarm     = (state_q == ST_LOCKOUT);
  assign entry_pos = pos_q;
  assign entered   = entered_q;
  assign fail_cnt  = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_combo_lock_checker.sv
// ============================================================================
// Module   : tb_combo_lock_checker
// Purpose  : Scoreboard bench for combo_lock_checker against a sequence-level
//            reference model (default build, COMBO_LOCK_PROGRAM_EN undefined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_combo_lock_checker;

  localparam int          CL     = 4;
  localparam int          DW     = 4;
  localparam int          MT     = 3;
  localparam int          LC     = 20;
  localparam logic [15:0] C_CODE = 16'h1234;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        enter = 1'b0;
  logic        clear = 1'b0;
  logic        unlocked;
  logic        alarm;
  logic [2:0]  entry_pos;
  logic [15:0] entered;
  logic [1:0]  fail_cnt;

  always #5 clk = ~clk;

  combo_lock_checker #(
    .CODE_LEN       (CL),
    .DIGIT_W        (DW),
    .CODE           (C_CODE),
    .MAX_TRIES      (MT),
    .LOCKOUT_CYCLES (LC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digit     (digit),
    .enter     (enter),
    .clear     (clear),
    .unlocked  (unlocked),
    .alarm     (alarm),
    .entry_pos (entry_pos),
    .entered   (entered),
    .fail_cnt  (fail_cnt)
  );

  typedef struct {
    logic        u;
    logic        a;
    int          pos;
    logic [15:0] ent;
    int          fc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: committed digits, failure count and countdowns.
  int m_digits[$];
  int m_fails;
  int m_settle;
  int m_lock;
  bit m_open;
  bit m_good;

  function automatic int code_digit(input int i);
    return int'((C_CODE >> ((CL - 1 - i) * DW)) & 16'h000F);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.u   = m_open;
    e.a   = (m_lock > 0);
    e.pos = m_digits.size();
    e.fc  = m_fails;
    e.ent = 16'h0000;
    foreach (m_digits[i]) e.ent = e.ent | (16'(m_digits[i] & 15) << ((CL - 1 - i) * DW));
    return e;
  endfunction

  task automatic model_reset();
    m_digits.delete();
    m_fails  = 0;
    m_settle = 0;
    m_lock   = 0;
    m_open   = 1'b0;
    m_good   = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit c, input int d);
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) begin
        m_fails = 0;
        m_digits.delete();
      end
    end else if (m_settle > 0) begin
      m_settle--;
      if (m_settle == 0) begin
        if (m_good) begin
          m_open  = 1'b1;
          m_fails = 0;
        end else begin
          m_fails++;
          m_digits.delete();
          if (m_fails == MT) m_lock = LC;
        end
      end
    end else if (m_open) begin
      if (e || c) begin
        m_open = 1'b0;
        m_digits.delete();
      end
    end else if (c) begin
      m_digits.delete();
    end else if (e) begin
      m_digits.push_back(d);
      if (m_digits.size() == CL) begin
        m_good = 1'b1;
        foreach (m_digits[i]) if (m_digits[i] != code_digit(i)) m_good = 1'b0;
        m_settle = m_good ? 1 : 2;
      end
    end
  endtask

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // One cycle of stimulus: drive after the edge, predict the next edge.
  task automatic cyc(input bit e, input bit c, input int d);
    @(posedge clk);
    #3;
    enter = e;
    clear = c;
    digit = 4'(d);
    model_step(e, c, d);
    sb.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0);
  endtask

  task automatic code4(input int a, input int b, input int c, input int d);
    cyc(1'b1, 1'b0, a);
    cyc(1'b1, 1'b0, b);
    cyc(1'b1, 1'b0, c);
    cyc(1'b1, 1'b0, d);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_unlocked"},  64'(unlocked),  0);
    chk({tag, "_alarm"},     64'(alarm),     0);
    chk({tag, "_entry_pos"}, 64'(entry_pos), 0);
    chk({tag, "_entered"},   64'(entered),   0);
    chk({tag, "_fail_cnt"},  64'(fail_cnt),  0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    @(posedge clk);
    #3;
    enter = 1'b0;
    clear = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("unlocked",  64'(unlocked),  64'(e.u));
        chk("alarm",     64'(alarm),     64'(e.a));
        chk("entry_pos", 64'(entry_pos), 64'(e.pos));
        chk("entered",   64'(entered),   64'(e.ent));
        chk("fail_cnt",  64'(fail_cnt),  64'(e.fc));
      end
    end
  end

  initial begin : stimulus
    int want;
    model_reset();
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;

    code4(1, 2, 3, 4);
    idle(3);
    cyc(1'b0, 1'b1, 0);
    idle(2);

    code4(1, 2, 3, 5);
    idle(3);

    cyc(1'b1, 1'b0, 1);
    cyc(1'b1, 1'b0, 2);
    cyc(1'b0, 1'b1, 0);
    idle(1);
    cyc(1'b1, 1'b0, 1);
    cyc(1'b1, 1'b1, 2);
    idle(1);

    code4(9, 9, 9, 9);
    idle(3);
    code4(1, 2, 3, 0);
    for (int k = 0; k < 28; k++) cyc(k[0], (k % 5) == 4, code_digit(k % CL));
    idle(2);

    code4(1, 2, 3, 4);
    idle(2);
    cyc(1'b1, 1'b0, 0);
    for (int t = 0; t < MT; t++) begin
      code4(4, 3, 2, 1);
      idle(3);
    end
    idle(6);
    pulse_reset();
    idle(2);

    for (int k = 0; k < 2500; k++) begin
      want = (m_digits.size() < CL) ? code_digit(m_digits.size()) : 0;
      if ($urandom_range(0, 99) < 12) cyc($urandom_range(0, 1) == 1, 1'b1, $urandom_range(0, 15));
      else if ($urandom_range(0, 99) < 45) cyc(1'b1, 1'b0, ($urandom_range(0, 99) < 75) ? want : $urandom_range(0, 15));
      else idle(1);
    end

    idle(3);
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
